// File: rtl/pipeline_stall_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : pipeline_stall_ctrl_if                                       |
// | Brief  : Hazard/branch inputs and stall/flush/status outputs of the   |
// |          pipeline stall controller.                                   |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             freeze;
  logic             bubble_ID_EXE;
  logic             flush_IF_ID;
  logic [1:0]       ctrl_state;
  logic             deadlock_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output hazard_detected, branch_taken,
    input  freeze, bubble_ID_EXE, flush_IF_ID, ctrl_state, deadlock_err,
           stall_cycles, flush_events
  );

  modport slave (
    input  hazard_detected, branch_taken,
    output freeze, bubble_ID_EXE, flush_IF_ID, ctrl_state, deadlock_err,
           stall_cycles, flush_events
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : pipeline_stall_ctrl                                          |
// | Brief  : Stall/flush controller with deadlock detection. Define       |
// |          PIPELINE_PERF_COUNTERS_EN to build the perf counters.        |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module pipeline_stall_ctrl #(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  pipeline_stall_ctrl_if.slave  bus_io
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [7:0] c_MAX_STALL = 8'(MAX_STALL);

  state_e     state_q;
  logic [7:0] consec_q;
  logic [7:0] consec_d;
  logic       deadlock_q;
  logic       w_freeze;
  logic       w_flush;

  // Reset gates every control output; FLUSH masks the hazard on the NOP in ID.
  assign w_flush  = !rst && bus_io.branch_taken;
  assign w_freeze = !rst && bus_io.hazard_detected && !bus_io.branch_taken
                    && (state_q != FLUSH);

  assign consec_d = w_freeze ? ((consec_q == 8'hFF) ? consec_q : consec_q + 8'd1)
                             : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      consec_q   <= 8'd0;
      deadlock_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus_io.branch_taken) state_q <= FLUSH;
          else if (w_freeze)       state_q <= STALL;
          else                     state_q <= RUN;
        end
        STALL: begin
          if (bus_io.branch_taken)         state_q <= FLUSH;
          else if (bus_io.hazard_detected) state_q <= STALL;
          else                             state_q <= RUN;
        end
        FLUSH: begin
          if (bus_io.branch_taken) state_q <= FLUSH;
          else                     state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
      consec_q <= consec_d;
      if (w_freeze && (consec_d == c_MAX_STALL)) deadlock_q <= 1'b1;
    end
  end

  assign bus_io.freeze        = w_freeze;
  assign bus_io.flush_IF_ID   = w_flush;
  assign bus_io.bubble_ID_EXE = w_freeze || w_flush;
  assign bus_io.ctrl_state    = state_q;
  assign bus_io.deadlock_err  = deadlock_q;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_freeze && !(&stall_cnt_q))            stall_cnt_q <= stall_cnt_q + 1'b1;
      if (bus_io.branch_taken && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus_io.stall_cycles = stall_cnt_q;
  assign bus_io.flush_events = flush_cnt_q;
`else
  assign bus_io.stall_cycles = {CNT_W{1'b0}};
  assign bus_io.flush_events = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_pipeline_stall_ctrl                                       |
// | Brief  : Scoreboard bench for pipeline_stall_ctrl (directed + random).|
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_pipeline_stall_ctrl;
  localparam int CW   = 4;
  localparam int MS   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_stall_ctrl #(.MAX_STALL(MS), .CNT_W(CW)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct packed {
    logic          freeze;
    logic          bubble;
    logic          flush;
    logic [1:0]    state;
    logic          dl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fe;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: state 0 RUN, 1 STALL, 2 FLUSH; plain integer counters.
  int m_state = 0;
  int m_run   = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_dl    = 1'b0;
  bit perf;

  initial begin
`ifdef PIPELINE_PERF_COUNTERS_EN
    perf = 1'b1;
`else
    perf = 1'b0;
`endif
  end

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step(input bit r, input bit hz, input bit br);
    exp_t e;
    bit   fz;
    @(posedge clk);
    #2;
    rst                 = r;
    bus.hazard_detected = hz;
    bus.branch_taken    = br;
    fz       = !r && hz && !br && (m_state != 2);
    e.freeze = fz;
    e.flush  = !r && br;
    e.bubble = fz || (!r && br);
    e.state  = 2'(m_state);
    e.dl     = m_dl;
    e.sc     = perf ? CW'(m_stall) : '0;
    e.fe     = perf ? CW'(m_flush) : '0;
    sb_q.push_back(e);
    if (r) begin
      m_state = 0; m_run = 0; m_stall = 0; m_flush = 0; m_dl = 1'b0;
    end else begin
      m_state = br ? 2 : (fz ? 1 : 0);
      m_run   = fz ? min2(m_run + 1, 255) : 0;
      if (m_run == MS) m_dl = 1'b1;
      m_stall = min2(m_stall + (fz ? 1 : 0), CMAX);
      m_flush = min2(m_flush + (br ? 1 : 0), CMAX);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("freeze",        32'(bus.freeze),        32'(e.freeze));
        chk("bubble_ID_EXE", 32'(bus.bubble_ID_EXE), 32'(e.bubble));
        chk("flush_IF_ID",   32'(bus.flush_IF_ID),   32'(e.flush));
        chk("ctrl_state",    32'(bus.ctrl_state),    32'(e.state));
        chk("deadlock_err",  32'(bus.deadlock_err),  32'(e.dl));
        chk("stall_cycles",  32'(bus.stall_cycles),  32'(e.sc));
        chk("flush_events",  32'(bus.flush_events),  32'(e.fe));
      end
    end
  end

  initial begin
    rst                 = 1'b1;
    bus.hazard_detected = 1'b0;
    bus.branch_taken    = 1'b0;
    step(1, 0, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    // load-use
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    // branch vs hazard, then hazard ignored in FLUSH
    step(0, 1, 1); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    // deadlock
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0);
    // reset mid-stall
    step(0, 1, 0); step(0, 1, 0); step(1, 1, 0); step(0, 0, 0);
    // counter saturation
    for (int i = 0; i < 20; i++) step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0);
    // back-to-back branches
    step(0, 0, 1); step(0, 1, 1); step(0, 1, 0); step(0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(($urandom % 40) == 0, $urandom % 2, ($urandom % 4) == 0);
    step(0, 0, 0);
    begin
      int budget;
      budget = 10;
      while (sb_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      if (sb_q.size() > 0) begin
        n_err++;
        $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
